// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed from a small byte FIFO; also holds the generic FIFO it uses.

// Generic synchronous FIFO with an explicit occupancy count.
// Latency: a write is visible at rdata one cycle after the push edge when the FIFO was empty.
// Backpressure: the caller must not push when count == DEPTH or pop when count == 0.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     wdata,
    input  logic             pop,
    output logic [W-1:0]     rdata,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Serialises queued bytes as 8N1 frames on a registered tx line.
// Latency: a byte pushed into an idle, empty block starts its start bit one cycle later.
// Backpressure: tx_ready drops while the FIFO holds FIFO_DEPTH bytes.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_count
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic [7:0]  head;
    logic        push;
    logic        pop;
    logic        baud_last;

    assign tx_ready  = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign push      = tx_valid && tx_ready;
    assign baud_last = (baud_cnt == BAUD_LAST);
    // Popping on the last stop cycle chains frames with no idle gap.
    assign pop       = (fifo_count != '0) &&
                       ((state == IDLE) || ((state == STOP) && baud_last));
    assign busy      = (state != IDLE) || (fifo_count != '0);

    fifo #(
        .W     (8),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (tx_data),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift    <= head;
                        baud_cnt <= '0;
                        state    <= START;
                        tx       <= 1'b0;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        tx       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            // tx takes the next bit now, so it stays a pure register.
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= head;
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 4 clocks per bit.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    int errors = 0;
    int checks = 0;

    uart_tx_fifo #(
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4),
        .CNT_W        (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Samples one 40-cycle frame starting at its first start-bit cycle.
    task automatic capture_frame(output logic [9:0] bits, output logic stable);
        logic first;
        first  = 1'b0;
        stable = 1'b1;
        bits   = '0;
        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 0) first = tx;
            else if (tx !== first) stable = 1'b0;
            bits[i/4] = tx;
            tick();
        end
    endtask

    task automatic test_reset();
        logic ok;
        rst_n = 1'b0; tx_valid = 1'b1; tx_data = 8'h99;
        tick(); tick(); tick();
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", tx_ready); end
        rst_n = 1'b1; tx_valid = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL reset_quiet: got %b expected 1", ok); end
    endtask

    task automatic test_single();
        logic [9:0] bits;
        logic       stable;
        tx_data = 8'hA5; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count_k: got %0d expected 1", fifo_count); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_k: got %b expected 1", tx); end
        tick();
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL single_start: got %b expected 0", tx); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
        capture_frame(bits, stable);
        checks++; if (bits !== 10'b1_1010_0101_0) begin errors++; $display("FAIL single_frame: got %b expected %b", bits, 10'b1_1010_0101_0); end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL single_stable: got %b expected 1", stable); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b expected 0", busy); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_idle_tx: got %b expected 1", tx); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] frames [5];
        logic       stab [5];
        logic       ok;
        fork
            begin
                tx_valid = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    tx_data = 8'(i + 1);
                    tick();
                end
                tx_valid = 1'b0;
                checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL b2b_full_count: got %0d expected 4", fifo_count); end
                checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b expected 0", tx_ready); end
                ok = 1'b1;
                for (int j = 0; j < 190; j++) begin
                    tick();
                    if (fifo_count > 3'd4 || tx_ready !== (fifo_count != 3'd4)) ok = 1'b0;
                end
                checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_ready_rule: got %b expected 1", ok); end
            end
            begin
                tick(); tick();
                for (int f = 0; f < 5; f++) capture_frame(frames[f], stab[f]);
            end
        join
        for (int f = 0; f < 5; f++) begin
            checks++;
            if (frames[f] !== {1'b1, 8'(f + 1), 1'b0} || stab[f] !== 1'b1) begin
                errors++;
                $display("FAIL b2b_frame%0d: got %b stable %b expected %b", f, frames[f], stab[f], {1'b1, 8'(f + 1), 1'b0});
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_end_busy: got %b expected 0", busy); end
    endtask

    task automatic test_full_hold();
        logic ok;
        tx_valid = 1'b1;
        tx_data = 8'h11; tick();
        tx_data = 8'h22; tick();
        tx_data = 8'h33; tick();
        tx_data = 8'h44; tick();
        tx_data = 8'hFF; tick();
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", fifo_count); end
        ok = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            tick();
            if (fifo_count > 3'd4) ok = 1'b0;
            if (j == 36) begin
                checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_held: got %0d expected 4", fifo_count); end
            end
            if (j == 37) begin
                checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL full_pop: got %0d expected 3", fifo_count); end
                checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready: got %b expected 1", tx_ready); end
            end
            if (j == 38) begin
                checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_refill: got %0d expected 4", fifo_count); end
            end
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL full_max: got %b expected 1", ok); end
        tx_valid = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_frame();
        logic ok;
        tx_valid = 1'b1;
        tx_data = 8'h55; tick();
        tx_data = 8'h66; tick();
        tx_data = 8'h77; tick();
        tx_valid = 1'b0;
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL mid_queued: got %0d expected 2", fifo_count); end
        for (int i = 0; i < 16; i++) tick();
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL mid_bit3: got %b expected 0", tx); end
        rst_n = 1'b0;
        tick();
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL mid_rst_tx: got %b expected 1", tx); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_rst_count: got %0d expected 0", fifo_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mid_quiet: got %b expected 1", ok); end
    endtask

    task automatic test_push_on_stop();
        logic [9:0] frames [3];
        logic       stab [3];
        logic [7:0] exp [3];
        exp[0] = 8'hA1; exp[1] = 8'hB2; exp[2] = 8'h3C;
        fork
            begin
                tx_valid = 1'b1;
                tx_data = 8'hA1; tick();
                tx_data = 8'hB2; tick();
                tx_valid = 1'b0;
                for (int i = 0; i < 39; i++) tick();
                checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL stop_pre_count: got %0d expected 1", fifo_count); end
                tx_data = 8'h3C; tx_valid = 1'b1;
                tick();
                tx_valid = 1'b0;
                checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL stop_post_count: got %0d expected 1", fifo_count); end
                checks++; if (tx !== 1'b0) begin errors++; $display("FAIL stop_next_start: got %b expected 0", tx); end
            end
            begin
                tick(); tick();
                for (int f = 0; f < 3; f++) capture_frame(frames[f], stab[f]);
            end
        join
        for (int f = 0; f < 3; f++) begin
            checks++;
            if (frames[f] !== {1'b1, exp[f], 1'b0} || stab[f] !== 1'b1) begin
                errors++;
                $display("FAIL stop_frame%0d: got %b stable %b expected %b", f, frames[f], stab[f], {1'b1, exp[f], 1'b0});
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_end_busy: got %b expected 0", busy); end
    endtask

    initial begin
        rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_full_hold();
        test_reset_mid_frame();
        test_push_on_stop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
